// File: rtl/alarm_ctrl_pkg.sv
// Shared state encoding for the alarm ring controller.
package alarm_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector. The input register loads every cycle,
// including during reset, so a level held across reset never yields a rise.
module rise_detect (
  input  logic clk,
  input  logic i_in,
  output logic o_rise
);

  logic r_in_q;

  always_ff @(posedge clk) begin
    r_in_q <= i_in;
  end

  assign o_rise = i_in & ~r_in_q;

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Alarm sound sequencer: ring on time match, bounded snooze, dismiss and
// ring timeout, driving the song player's play and restart controls.
module alarm_ring_ctrl
  import alarm_ctrl_pkg::*;
#(
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 300,
  parameter int MAX_SNOOZES    = 3,
  parameter int CNT_W          = 9
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             sec_tick,
  input  logic                             alarm_on,
  input  logic                             alarm_match,
  input  logic                             snooze_key,
  input  logic                             dismiss_key,
  output logic                             play_sound,
  output logic                             song_restart,
  output logic                             snoozing,
  output logic [1:0]                       ctrl_state,
  output logic [CNT_W-1:0]                 remaining,
  output logic [$clog2(MAX_SNOOZES+1)-1:0] snooze_count
);

  localparam int SC_W = $clog2(MAX_SNOOZES + 1);
  localparam logic [CNT_W-1:0] RING_INIT   = CNT_W'(RING_TIMEOUT_S);
  localparam logic [CNT_W-1:0] SNOOZE_INIT = CNT_W'(SNOOZE_S);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [SC_W-1:0]  SC_MAX      = SC_W'(MAX_SNOOZES);
  localparam logic [SC_W-1:0]  SC_ONE      = SC_W'(1);

  logic w_match_rise;
  logic w_snooze_rise;
  logic w_dismiss_rise;

  ctrl_state_e         r_state;
  logic                r_play;
  logic                r_restart;
  logic                r_snoozing;
  logic [CNT_W-1:0]    r_remaining;
  logic [SC_W-1:0]     r_snooze_cnt;

  rise_detect u_match_rise (
    .clk    (clk),
    .i_in   (alarm_match),
    .o_rise (w_match_rise)
  );

  rise_detect u_snooze_rise (
    .clk    (clk),
    .i_in   (snooze_key),
    .o_rise (w_snooze_rise)
  );

  rise_detect u_dismiss_rise (
    .clk    (clk),
    .i_in   (dismiss_key),
    .o_rise (w_dismiss_rise)
  );

  // Rises are combinational against the registered copy, so an event seen at
  // an edge changes state and all registered outputs on that same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_play       <= 1'b0;
      r_restart    <= 1'b0;
      r_snoozing   <= 1'b0;
      r_remaining  <= '0;
      r_snooze_cnt <= '0;
    end else begin
      r_restart <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (alarm_on && w_match_rise) begin
            r_state      <= ST_RINGING;
            r_play       <= 1'b1;
            r_restart    <= 1'b1;
            r_snoozing   <= 1'b0;
            r_remaining  <= RING_INIT;
            r_snooze_cnt <= '0;
          end else begin
            r_state      <= ST_IDLE;
            r_play       <= 1'b0;
            r_snoozing   <= 1'b0;
            r_remaining  <= '0;
            r_snooze_cnt <= '0;
          end
        end

        ST_RINGING, ST_SNOOZE: begin
          if (!alarm_on || w_dismiss_rise) begin
            r_state      <= ST_IDLE;
            r_play       <= 1'b0;
            r_snoozing   <= 1'b0;
            r_remaining  <= '0;
            r_snooze_cnt <= '0;
          end else if (r_state == ST_RINGING && w_snooze_rise &&
                       r_snooze_cnt < SC_MAX) begin
            r_state      <= ST_SNOOZE;
            r_play       <= 1'b0;
            r_snoozing   <= 1'b1;
            r_remaining  <= SNOOZE_INIT;
            r_snooze_cnt <= r_snooze_cnt + SC_ONE;
          end else if (sec_tick) begin
            if (r_remaining > CNT_ONE) begin
              r_remaining <= r_remaining - CNT_ONE;
            end else if (r_state == ST_RINGING) begin
              r_state      <= ST_IDLE;
              r_play       <= 1'b0;
              r_snoozing   <= 1'b0;
              r_remaining  <= '0;
              r_snooze_cnt <= '0;
            end else begin
              // Snooze expired: ring again from the top of the song.
              r_state     <= ST_RINGING;
              r_play      <= 1'b1;
              r_restart   <= 1'b1;
              r_snoozing  <= 1'b0;
              r_remaining <= RING_INIT;
            end
          end
        end

        default: begin
          r_state      <= ST_IDLE;
          r_play       <= 1'b0;
          r_snoozing   <= 1'b0;
          r_remaining  <= '0;
          r_snooze_cnt <= '0;
        end
      endcase
    end
  end

  assign play_sound   = r_play;
  assign song_restart = r_restart;
  assign snoozing     = r_snoozing;
  assign ctrl_state   = r_state;
  assign remaining    = r_remaining;
  assign snooze_count = r_snooze_cnt;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Bench for alarm_ring_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_alarm_ring_ctrl;

  localparam int RING = 5;
  localparam int SNZ  = 3;
  localparam int MAXS = 2;
  localparam int CW   = 4;
  localparam int SCW  = $clog2(MAXS + 1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sec_tick = 1'b0;
  logic alarm_on = 1'b0;
  logic alarm_match = 1'b0;
  logic snooze_key = 1'b0;
  logic dismiss_key = 1'b0;
  logic play_sound, song_restart, snoozing;
  logic [1:0] ctrl_state;
  logic [CW-1:0] remaining;
  logic [SCW-1:0] snooze_count;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  alarm_ring_ctrl #(
    .RING_TIMEOUT_S (RING),
    .SNOOZE_S       (SNZ),
    .MAX_SNOOZES    (MAXS),
    .CNT_W          (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sec_tick     (sec_tick),
    .alarm_on     (alarm_on),
    .alarm_match  (alarm_match),
    .snooze_key   (snooze_key),
    .dismiss_key  (dismiss_key),
    .play_sound   (play_sound),
    .song_restart (song_restart),
    .snoozing     (snoozing),
    .ctrl_state   (ctrl_state),
    .remaining    (remaining),
    .snooze_count (snooze_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: mode 0 = silent, 1 = ringing, 2 = snoozing.
  int  m_mode = 0;
  int  m_left = 0;
  int  m_used = 0;
  bit  m_restart = 1'b0;
  bit  prev_match = 1'b0, prev_snz = 1'b0, prev_dis = 1'b0;

  always @(posedge clk) begin
    bit new_match, new_snz, new_dis;
    new_match  = alarm_match && !prev_match;
    new_snz    = snooze_key && !prev_snz;
    new_dis    = dismiss_key && !prev_dis;
    prev_match = alarm_match;
    prev_snz   = snooze_key;
    prev_dis   = dismiss_key;
    m_restart  = 1'b0;
    if (reset) begin
      m_mode = 0; m_left = 0; m_used = 0;
    end else if (m_mode == 0) begin
      if (alarm_on && new_match) begin
        m_mode = 1; m_left = RING; m_used = 0; m_restart = 1'b1;
      end
    end else if (!alarm_on || new_dis) begin
      m_mode = 0; m_left = 0; m_used = 0;
    end else if (m_mode == 1 && new_snz && m_used < MAXS) begin
      m_mode = 2; m_left = SNZ; m_used = m_used + 1;
    end else if (sec_tick) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        if (m_mode == 1) begin
          m_mode = 0; m_used = 0;
        end else begin
          m_mode = 1; m_left = RING; m_restart = 1'b1;
        end
      end
    end
    #1;
    if (chk_en) begin
      chk("play_sound",   int'(play_sound),   int'(m_mode == 1));
      chk("snoozing",     int'(snoozing),     int'(m_mode == 2));
      chk("song_restart", int'(song_restart), int'(m_restart));
      chk("ctrl_state",   int'(ctrl_state),   m_mode);
      chk("remaining",    int'(remaining),    m_left);
      chk("snooze_count", int'(snooze_count), m_used);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic tick();
    sec_tick = 1'b1;
    cyc(1);
    sec_tick = 1'b0;
  endtask

  task automatic ring_up();
    alarm_match = 1'b0;
    cyc(1);
    alarm_match = 1'b1;
    cyc(1);
    alarm_match = 1'b0;
  endtask

  initial begin
    cyc(2);
    chk_en = 1'b1;
    reset = 1'b0;
    cyc(1);
    chk("rst_state", int'(ctrl_state), 0);
    chk("rst_play", int'(play_sound), 0);
    chk("rst_remaining", int'(remaining), 0);

    // Ring start; the held match must not pulse restart again.
    alarm_on = 1'b1;
    cyc(1);
    alarm_match = 1'b1;
    cyc(1);
    chk("start_state", int'(ctrl_state), 1);
    chk("start_remaining", int'(remaining), 5);
    chk("start_restart", int'(song_restart), 1);
    chk("model_left", m_left, 5);
    cyc(1);
    chk("start_restart_off", int'(song_restart), 0);

    // Timeout with alarm_match still high: no retrigger.
    for (int k = 4; k >= 1; k--) begin
      tick();
      chk("timeout_step", int'(remaining), k);
    end
    tick();
    chk("timeout_state", int'(ctrl_state), 0);
    chk("timeout_play", int'(play_sound), 0);
    cyc(2);
    chk("no_retrigger", int'(ctrl_state), 0);

    // Snooze cycle.
    ring_up();
    snooze_key = 1'b1;
    cyc(1);
    snooze_key = 1'b0;
    chk("snz_state", int'(ctrl_state), 2);
    chk("snz_remaining", int'(remaining), 3);
    chk("snz_count", int'(snooze_count), 1);
    tick(); tick(); tick();
    chk("snz_back_state", int'(ctrl_state), 1);
    chk("snz_back_restart", int'(song_restart), 1);
    chk("snz_back_remaining", int'(remaining), 5);
    chk("snz_back_count", int'(snooze_count), 1);

    // Second snooze, then the third is refused.
    snooze_key = 1'b1;
    cyc(1);
    snooze_key = 1'b0;
    chk("snz2_count", int'(snooze_count), 2);
    tick(); tick(); tick();
    snooze_key = 1'b1;
    cyc(1);
    snooze_key = 1'b0;
    chk("snz_limit_state", int'(ctrl_state), 1);
    chk("snz_limit_count", int'(snooze_count), 2);
    tick();
    chk("snz_limit_count_down", int'(remaining), 4);
    dismiss_key = 1'b1;
    cyc(1);
    dismiss_key = 1'b0;
    chk("dismiss_state", int'(ctrl_state), 0);

    // Dismiss plus snooze together.
    ring_up();
    dismiss_key = 1'b1;
    snooze_key = 1'b1;
    cyc(1);
    dismiss_key = 1'b0;
    snooze_key = 1'b0;
    chk("dis_snz_state", int'(ctrl_state), 0);
    chk("dis_snz_count", int'(snooze_count), 0);

    // Snooze plus tick together, then alarm_on dropped mid-snooze.
    ring_up();
    snooze_key = 1'b1;
    sec_tick = 1'b1;
    cyc(1);
    snooze_key = 1'b0;
    sec_tick = 1'b0;
    chk("snz_tick_state", int'(ctrl_state), 2);
    chk("snz_tick_remaining", int'(remaining), 3);
    alarm_on = 1'b0;
    cyc(1);
    chk("off_state", int'(ctrl_state), 0);
    alarm_on = 1'b1;

    // Reset while ringing with snooze held.
    ring_up();
    snooze_key = 1'b1;
    reset = 1'b1;
    cyc(1);
    chk("rst_mid_play", int'(play_sound), 0);
    chk("rst_mid_state", int'(ctrl_state), 0);
    reset = 1'b0;
    cyc(2);
    chk("rst_held_key", int'(ctrl_state), 0);
    snooze_key = 1'b0;
    cyc(1);
    snooze_key = 1'b1;
    cyc(1);
    snooze_key = 1'b0;
    chk("rst_key_idle", int'(ctrl_state), 0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      reset       = ($urandom_range(0, 199) == 0);
      alarm_on    = ($urandom_range(0, 49) != 0);
      sec_tick    = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) alarm_match = ~alarm_match;
      if ($urandom_range(0, 5) == 0) snooze_key  = ~snooze_key;
      if ($urandom_range(0, 29) == 0) dismiss_key = ~dismiss_key;
      cyc(1);
    end
    reset = 1'b0;
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
